// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: one-cycle hits, and 4-byte line refills over a shared
// byte-wide memory port with grant loss, flush abort and a global rdy freeze.
module icache_refill_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    input  logic        flush_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_inst_o,
    output logic [31:0] ic_raddr_o,
    input  logic        ic_hit_i,
    input  logic [31:0] ic_inst_i,
    output logic        ic_we_o,
    output logic [31:0] ic_waddr_o,
    output logic [31:0] ic_winst_o,
    output logic        mem_req_o,
    input  logic        mem_grant_i,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_din_i
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_GNT, S_FILL, S_WRITE} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_issue_cnt, w_issue_cnt_nxt;
    logic [2:0]  r_recv_cnt, w_recv_cnt_nxt;
    logic        r_pend, w_pend_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_word, w_word_nxt;
    logic        r_fetch_valid, w_fetch_valid_nxt;
    logic [31:0] r_fetch_inst, w_fetch_inst_nxt;
    logic        r_ic_we, w_ic_we_nxt;
    logic        w_issue;
    logic        w_unused;

    // Byte k of the line is issued while the port is owned; its data lands the following cycle.
    assign w_issue    = (r_state == S_FILL) && mem_grant_i && !r_issue_cnt[2];
    assign w_unused   = ^fetch_addr_i[1:0];

    assign ic_raddr_o    = {fetch_addr_i[31:2], 2'b00};
    assign mem_req_o     = (r_state == S_WAIT_GNT) || (r_state == S_FILL);
    assign mem_addr_o    = ((r_state == S_FILL) && !r_issue_cnt[2]) ? r_addr + {29'd0, r_issue_cnt} : 32'd0;
    assign fetch_valid_o = r_fetch_valid;
    assign fetch_inst_o  = r_fetch_inst;
    assign ic_we_o       = r_ic_we;
    assign ic_waddr_o    = r_addr;
    assign ic_winst_o    = r_word;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        w_state_nxt       = r_state;
        w_issue_cnt_nxt   = r_issue_cnt;
        w_recv_cnt_nxt    = r_recv_cnt;
        w_pend_nxt        = r_pend;
        w_addr_nxt        = r_addr;
        w_word_nxt        = r_word;
        w_fetch_valid_nxt = 1'b0;
        w_fetch_inst_nxt  = r_fetch_inst;
        w_ic_we_nxt       = 1'b0;

        if (flush_i) begin
            w_state_nxt = S_IDLE;
            w_pend_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fetch_req_i) begin
                        if (ic_hit_i) begin
                            w_fetch_valid_nxt = 1'b1;
                            w_fetch_inst_nxt  = ic_inst_i;
                        end else begin
                            w_addr_nxt  = {15'd0, fetch_addr_i[16:2], 2'b00};
                            w_state_nxt = S_WAIT_GNT;
                        end
                    end
                end
                S_WAIT_GNT: begin
                    if (mem_grant_i) begin
                        w_state_nxt     = S_FILL;
                        w_issue_cnt_nxt = 3'd0;
                        w_recv_cnt_nxt  = 3'd0;
                        w_pend_nxt      = 1'b0;
                        w_word_nxt      = 32'd0;
                    end
                end
                S_FILL: begin
                    if (r_pend) begin
                        w_word_nxt[{r_recv_cnt[1:0], 3'b000} +: 8] = mem_din_i;
                        w_recv_cnt_nxt = r_recv_cnt + 3'd1;
                    end
                    // A grant drop only stalls issue; the byte already in flight still lands.
                    w_pend_nxt = w_issue;
                    if (w_issue) begin
                        w_issue_cnt_nxt = r_issue_cnt + 3'd1;
                    end
                    if (r_pend && (r_recv_cnt == 3'd3)) begin
                        w_state_nxt       = S_WRITE;
                        w_fetch_valid_nxt = 1'b1;
                        w_ic_we_nxt       = 1'b1;
                        w_fetch_inst_nxt  = w_word_nxt;
                    end
                end
                S_WRITE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            r_state       <= S_IDLE;
            r_issue_cnt   <= 3'd0;
            r_recv_cnt    <= 3'd0;
            r_pend        <= 1'b0;
            r_addr        <= 32'd0;
            r_word        <= 32'd0;
            r_fetch_valid <= 1'b0;
            r_fetch_inst  <= 32'd0;
            r_ic_we       <= 1'b0;
        end else if (rdy) begin
            r_state       <= w_state_nxt;
            r_issue_cnt   <= w_issue_cnt_nxt;
            r_recv_cnt    <= w_recv_cnt_nxt;
            r_pend        <= w_pend_nxt;
            r_addr        <= w_addr_nxt;
            r_word        <= w_word_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
            r_fetch_inst  <= w_fetch_inst_nxt;
            r_ic_we       <= w_ic_we_nxt;
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a transaction-level reference model checked every cycle,
// plus hand-computed latencies and words for each scenario.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, fetch_req_i, flush_i, ic_hit_i, mem_grant_i;
    logic [31:0] fetch_addr_i, ic_inst_i;
    logic        fetch_valid_o, ic_we_o, mem_req_o;
    logic [31:0] fetch_inst_o, ic_raddr_o, ic_waddr_o, ic_winst_o, mem_addr_o;
    logic [7:0]  mem_din_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .flush_i(flush_i),
        .fetch_valid_o(fetch_valid_o), .fetch_inst_o(fetch_inst_o), .ic_raddr_o(ic_raddr_o),
        .ic_hit_i(ic_hit_i), .ic_inst_i(ic_inst_i),
        .ic_we_o(ic_we_o), .ic_waddr_o(ic_waddr_o), .ic_winst_o(ic_winst_o),
        .mem_req_o(mem_req_o), .mem_grant_i(mem_grant_i), .mem_addr_o(mem_addr_o),
        .mem_din_i(mem_din_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed instruction at 0x204, an address hash elsewhere.
    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'h204: return 8'h93;
            32'h205: return 8'h00;
            32'h206: return 8'h10;
            32'h207: return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
    endfunction

    // Byte-wide memory: returns the byte of the address driven while owned on the previous enabled edge.
    logic [31:0] mem_last = 32'd0;
    logic [31:0] issued_q[$];
    assign mem_din_i = byte_at(mem_last);

    always @(posedge clk) begin
        if (!rst && rdy && mem_req_o && mem_grant_i) begin
            mem_last <= mem_addr_o;
            if (mem_addr_o != 32'd0) issued_q.push_back(mem_addr_o);
        end
    end

    // Reference model: refill progress tracked as a list of collected bytes plus one in-flight flag.
    typedef enum {M_IDLE, M_WAIT, M_FILL, M_WRITE} mphase_t;
    mphase_t     m_phase    = M_IDLE;
    logic [31:0] m_addr     = 32'd0;
    logic [7:0]  m_bytes[$];
    bit          m_inflight = 1'b0;
    bit          e_valid    = 1'b0;
    bit          e_we       = 1'b0;
    logic [31:0] e_inst     = 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = M_IDLE;
            m_bytes.delete();
            m_inflight = 1'b0;
            e_valid = 1'b0;
            e_we = 1'b0;
            e_inst = 32'd0;
        end else if (rdy) begin
            e_valid = 1'b0;
            e_we = 1'b0;
            if (flush_i) begin
                m_phase = M_IDLE;
            end else begin
                case (m_phase)
                    M_IDLE: if (fetch_req_i) begin
                        if (ic_hit_i) begin
                            e_valid = 1'b1;
                            e_inst = ic_inst_i;
                        end else begin
                            m_addr = fetch_addr_i & 32'h0001_FFFC;
                            m_phase = M_WAIT;
                        end
                    end
                    M_WAIT: if (mem_grant_i) begin
                        m_phase = M_FILL;
                        m_bytes.delete();
                        m_inflight = 1'b0;
                    end
                    M_FILL: begin
                        if (m_inflight) m_bytes.push_back(byte_at(m_addr + 32'(m_bytes.size())));
                        m_inflight = mem_grant_i && (m_bytes.size() < 4);
                        if (m_bytes.size() == 4) begin
                            e_inst = 32'd0;
                            foreach (m_bytes[k]) e_inst |= 32'(m_bytes[k]) << (8 * k);
                            e_valid = 1'b1;
                            e_we = 1'b1;
                            m_phase = M_WRITE;
                        end
                    end
                    M_WRITE: m_phase = M_IDLE;
                    default: m_phase = M_IDLE;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("fetch_valid", 32'(fetch_valid_o), 32'(e_valid));
        check("ic_we", 32'(ic_we_o), 32'(e_we));
        check("mem_req", 32'(mem_req_o), 32'((m_phase == M_WAIT) || (m_phase == M_FILL)));
        check("ic_raddr", ic_raddr_o, {fetch_addr_i[31:2], 2'b00});
        if (e_valid) check("fetch_inst", fetch_inst_o, e_inst);
        if (e_we) begin
            check("ic_waddr", ic_waddr_o, m_addr);
            check("ic_winst", ic_winst_o, e_inst);
        end
        if (m_phase == M_FILL && (m_bytes.size() + int'(m_inflight)) < 4)
            check("mem_addr", mem_addr_o, m_addr + 32'(m_bytes.size()) + 32'(m_inflight));
    end

    // One request; bit n of gnt_pat/rdy_pat applies at the n-th clock edge after the request appears.
    task automatic run_txn(input logic [31:0] addr, input logic hit, input logic [31:0] inst,
                           input logic [31:0] gnt_pat, input logic [31:0] rdy_pat,
                           input int flush_at, input int ncyc,
                           output int lat, output int n_valid, output int n_we,
                           output logic [31:0] word, output logic [31:0] waddr);
        lat = -1; n_valid = 0; n_we = 0; word = 32'hx; waddr = 32'hx;
        issued_q.delete();
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            fetch_req_i  = (n_valid == 0) && (n <= flush_at);
            fetch_addr_i = addr;
            ic_hit_i     = hit;
            ic_inst_i    = inst;
            mem_grant_i  = gnt_pat[n];
            rdy          = rdy_pat[n];
            flush_i      = (n == flush_at);
            @(posedge clk);
            #1;
            if (n == flush_at) check("mem_req after flush", 32'(mem_req_o), 32'd0);
            if (rdy_pat[n]) begin
                if (fetch_valid_o) begin
                    n_valid++;
                    if (lat < 0) lat = n + 1;
                    word = fetch_inst_o;
                end
                if (ic_we_o) begin
                    n_we++;
                    waddr = ic_waddr_o;
                end
            end
        end
        @(negedge clk);
        fetch_req_i = 1'b0; flush_i = 1'b0; mem_grant_i = 1'b0; rdy = 1'b1; ic_hit_i = 1'b0;
    endtask

    task automatic check_issue(input string name, input logic [31:0] base);
        check({name, " issue count"}, 32'(issued_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < issued_q.size(); k++)
            check({name, " issue addr"}, issued_q[k], base + 32'(k));
    endtask

    int          lat, nv, nwe;
    logic [31:0] word, waddr;

    initial begin
        rst = 1'b1; rdy = 1'b1; fetch_req_i = 1'b0; flush_i = 1'b0; ic_hit_i = 1'b0;
        mem_grant_i = 1'b0; fetch_addr_i = 32'd0; ic_inst_i = 32'd0;
        repeat (3) @(negedge clk);
        check("reset fetch_valid", 32'(fetch_valid_o), 32'd0);
        check("reset mem_req", 32'(mem_req_o), 32'd0);
        check("reset mem_addr", mem_addr_o, 32'd0);
        rst = 1'b0;

        // Hit at 0x100: one-cycle latency, memory untouched.
        run_txn(32'h100, 1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 99, 4, lat, nv, nwe, word, waddr);
        check("hit latency", 32'(lat), 32'd1);
        check("hit inst", word, 32'h0000_0013);
        check("hit no fill", 32'(nwe), 32'd0);
        check("hit no mem issue", 32'(issued_q.size()), 32'd0);

        // Miss at 0x204 with immediate grant.
        run_txn(32'h204, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 99, 12, lat, nv, nwe, word, waddr);
        check("miss latency", 32'(lat), 32'd7);
        check("miss word", word, 32'h0010_0093);
        check("miss waddr", waddr, 32'h204);
        check("miss we pulses", 32'(nwe), 32'd1);
        check_issue("miss", 32'h204);

        // Grant delayed 3 cycles, dropped for 2 cycles after byte 1.
        run_txn(32'h300, 1'b0, 32'h0, 32'hFFFF_FE70, 32'hFFFF_FFFF, 99, 18, lat, nv, nwe, word, waddr);
        check("gnt-drop latency", 32'(lat), 32'd12);
        check("gnt-drop word", word, 32'h5A5B_5859);
        check("gnt-drop we pulses", 32'(nwe), 32'd1);
        check_issue("gnt-drop", 32'h300);

        // Flush after two bytes have arrived.
        run_txn(32'h204, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 14, lat, nv, nwe, word, waddr);
        check("flush-fill valid", 32'(nv), 32'd0);
        check("flush-fill we", 32'(nwe), 32'd0);

        // Flush together with a hitting request in IDLE: request dropped.
        run_txn(32'h100, 1'b1, 32'h0000_0013, 32'h0, 32'hFFFF_FFFF, 0, 3, lat, nv, nwe, word, waddr);
        check("flush-idle valid", 32'(nv), 32'd0);

        // rdy low for three cycles mid-fill: same word, three cycles later.
        run_txn(32'h204, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFC7, 99, 16, lat, nv, nwe, word, waddr);
        check("stall latency", 32'(lat), 32'd10);
        check("stall word", word, 32'h0010_0093);
        check("stall we pulses", 32'(nwe), 32'd1);
        check_issue("stall", 32'h204);

        // Address bits [1:0] and [31:17] are ignored for the refill.
        run_txn(32'hABC0_030B, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 99, 12, lat, nv, nwe, word, waddr);
        check("masked waddr", waddr, 32'h308);
        check("masked word", word, word_at(32'h308));
        check("masked latency", 32'(lat), 32'd7);

        // Reset while waiting for grant, then a hit the very next cycle.
        @(negedge clk);
        fetch_req_i = 1'b1; fetch_addr_i = 32'h400; ic_hit_i = 1'b0; mem_grant_i = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-reset waiting", 32'(mem_req_o), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst fetch_valid", 32'(fetch_valid_o), 32'd0);
        check("rst fetch_inst", fetch_inst_o, 32'd0);
        check("rst ic_we", 32'(ic_we_o), 32'd0);
        check("rst mem_req", 32'(mem_req_o), 32'd0);
        check("rst mem_addr", mem_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b0; fetch_addr_i = 32'h500; ic_hit_i = 1'b1; ic_inst_i = 32'hCAFE_0013;
        @(posedge clk);
        #1;
        check("post-rst hit valid", 32'(fetch_valid_o), 32'd1);
        check("post-rst hit inst", fetch_inst_o, 32'hCAFE_0013);
        @(negedge clk);
        fetch_req_i = 1'b0; ic_hit_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
